// File: rtl/rk2040_pkg.sv
// Shared constants for the rk2040 core: opcodes, IN/OUT selectors, system sub-ops, ISR vector.
// Also holds the ROM images as a constant lookup, so no data file is needed at elaboration.
package rk2040_pkg;

    localparam int         ROM_DEPTH = 256;
    localparam logic [7:0] ISR_VEC   = 8'h80;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SHL, OP_SHR, OP_IN, OP_OUT, OP_JMP, OP_JZ, OP_JNZ, OP_SYS
    } opcode_e;

    typedef enum logic [1:0] {SYS_HALT, SYS_RETI, SYS_EI, SYS_DI} sysop_e;

    localparam logic [2:0] IN_P0 = 3'd0, IN_P1 = 3'd1, IN_P2 = 3'd2;
    localparam logic [2:0] IN_ADC0 = 3'd3, IN_ADC1 = 3'd4, IN_ADC2 = 3'd5;
    localparam logic [1:0] OUT_NONE = 2'd3;

    function automatic logic [15:0] enc_i(opcode_e op, logic [2:0] rd, logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] enc_r(opcode_e op, logic [2:0] rd, logic [2:0] rs);
        return {op, rd, rs, 6'b000000};
    endfunction

    // Image 1: arithmetic/branch demo, ADC and port echo loop with a maskable HALT, and a short ISR.
    function automatic logic [15:0] rom_word(int prog, logic [7:0] addr);
        if (prog != 1) return 16'h0000;
        case (addr)
            8'h00: return enc_i(OP_LDI, 3'd1, 8'h05);
            8'h01: return enc_i(OP_LDI, 3'd2, 8'h03);
            8'h02: return enc_r(OP_ADD, 3'd1, 3'd2);
            8'h03: return enc_i(OP_OUT, 3'd1, 8'h00);
            8'h04: return enc_i(OP_LDI, 3'd1, 8'hFF);
            8'h05: return enc_i(OP_LDI, 3'd2, 8'h01);
            8'h06: return enc_r(OP_ADD, 3'd1, 3'd2);
            8'h07: return enc_i(OP_JZ,  3'd0, 8'h09);
            8'h08: return enc_i(OP_OUT, 3'd2, 8'h01);
            8'h09: return enc_i(OP_LDI, 3'd3, 8'h40);
            8'h0A: return enc_i(OP_OUT, 3'd3, 8'h04);
            8'h0B: return enc_i(OP_IN,  3'd4, 8'h03);
            8'h0C: return enc_i(OP_IN,  3'd5, 8'h04);
            8'h0D: return enc_i(OP_IN,  3'd6, 8'h05);
            8'h0E: return enc_i(OP_OUT, 3'd4, 8'h00);
            8'h0F: return enc_i(OP_OUT, 3'd5, 8'h01);
            8'h10: return enc_i(OP_OUT, 3'd6, 8'h02);
            8'h11: return enc_i(OP_IN,  3'd4, 8'h00);
            8'h12: return enc_i(OP_IN,  3'd5, 8'h01);
            8'h13: return enc_r(OP_SUB, 3'd4, 3'd5);
            8'h14: return enc_r(OP_MOV, 3'd7, 3'd4);
            8'h15: return enc_r(OP_XOR, 3'd4, 3'd6);
            8'h16: return enc_r(OP_OR,  3'd7, 3'd5);
            8'h17: return enc_r(OP_AND, 3'd7, 3'd4);
            8'h18: return enc_r(OP_SHL, 3'd4, 3'd0);
            8'h19: return enc_r(OP_SHR, 3'd5, 3'd0);
            8'h1A: return enc_r(OP_ADD, 3'd4, 3'd5);
            8'h1B: return enc_i(OP_OUT, 3'd4, 8'h06);
            8'h1C: return enc_i(OP_OUT, 3'd7, 8'h07);
            8'h1D: return enc_i(OP_OUT, 3'd5, 8'h03);
            8'h1E: return enc_i(OP_SYS, 3'd0, 8'h01);
            8'h1F: return enc_i(OP_JMP, 3'd0, 8'h21);
            8'h20: return enc_i(OP_OUT, 3'd2, 8'h01);
            8'h21: return enc_i(OP_SYS, 3'd0, 8'h03);
            8'h22: return enc_i(OP_IN,  3'd7, 8'h02);
            8'h23: return enc_i(OP_LDI, 3'd0, 8'h03);
            8'h24: return enc_r(OP_AND, 3'd7, 3'd0);
            8'h25: return enc_i(OP_SYS, 3'd0, 8'h02);
            8'h26: return enc_i(OP_JNZ, 3'd0, 8'h0B);
            8'h27: return enc_i(OP_SYS, 3'd0, 8'h00);
            8'h80: return enc_i(OP_IN,  3'd6, 8'h06);
            8'h81: return enc_i(OP_LDI, 3'd0, 8'h01);
            8'h82: return enc_r(OP_ADD, 3'd3, 3'd0);
            8'h83: return enc_i(OP_OUT, 3'd3, 8'h05);
            8'h84: return enc_i(OP_OUT, 3'd3, 8'h02);
            8'h85: return enc_r(OP_SUB, 3'd0, 3'd0);
            8'h86: return enc_i(OP_SYS, 3'd0, 8'h01);
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/rk2040_if.sv
// Port bundle of the rk2040 core: general input, ADC samples, output port and PWM pins.
// The core takes the slave side; whatever drives the inputs takes the master side.
interface rk2040_if;
    logic [23:0] inputPort;
    logic [7:0]  ADC0;
    logic [7:0]  ADC1;
    logic [7:0]  ADC2;
    logic [23:0] outputPort;
    logic [3:0]  outputPWM;

    modport master (output inputPort, ADC0, ADC1, ADC2, input outputPort, outputPWM);
    modport slave  (input inputPort, ADC0, ADC1, ADC2, output outputPort, outputPWM);
endinterface

// File: rtl/rk2040_pwm.sv
// Four PWM channels on a free-running 8-bit counter; output registered one cycle behind the compare.
// Duty writes land at the next edge; no backpressure.
module rk2040_pwm (
    input  logic       clk,
    input  logic       rst,
    input  logic       duty_wr,
    input  logic [1:0] duty_sel,
    input  logic [7:0] duty_dat,
    output logic [3:0] pwm
);
    logic [7:0] cnt;
    logic [7:0] duty [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            pwm <= 4'd0;
            for (int i = 0; i < 4; i++) duty[i] <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
            if (duty_wr) duty[duty_sel] <= duty_dat;
            for (int i = 0; i < 4; i++) pwm[i] <= (cnt < duty[i]);
        end
    end
endmodule

// File: rtl/rk2040.sv
// 8-bit microcontroller core: one instruction per cycle from a combinational ROM, edge interrupt at 0x80.
// Register, flag and port writes land at the next edge; no backpressure.
import rk2040_pkg::*;

module rk2040 #(
    parameter int PROGRAM = 1
) (
    input  logic    clk,
    input  logic    rst,
    rk2040_if.slave io
);
    logic [7:0]  pc, pc_n, epc;
    logic [7:0]  regs [8];
    logic        z, c, ez, ec, ie, in_service, pending;
    logic        sync1, sync2, sync_prev;
    logic [15:0] instr;
    opcode_e     op;
    logic [2:0]  rd, rs;
    logic [7:0]  imm, a, b, res, in_val;
    logic [8:0]  sum;
    logic [23:0] out_port;
    logic        reg_wr, z_n, c_n, ie_n, svc_clr, port_wr, duty_wr, take, fall, alu_op;

    assign instr  = rom_word(PROGRAM, pc);
    assign op     = opcode_e'(instr[15:12]);
    assign rd     = instr[11:9];
    assign rs     = instr[8:6];
    assign imm    = instr[7:0];
    assign a      = regs[rd];
    assign b      = regs[rs];
    assign take   = pending & ie & ~in_service;
    assign fall   = ~sync2 & sync_prev;
    assign alu_op = (op >= OP_ADD) && (op <= OP_SHR);

    always_comb begin
        case (imm[2:0])
            IN_P0:   in_val = io.inputPort[7:0];
            IN_P1:   in_val = io.inputPort[15:8];
            IN_P2:   in_val = io.inputPort[23:16];
            IN_ADC0: in_val = io.ADC0;
            IN_ADC1: in_val = io.ADC1;
            IN_ADC2: in_val = io.ADC2;
            default: in_val = 8'd0;
        endcase
    end

    always_comb begin
        pc_n    = pc + 8'd1;
        res     = 8'd0;
        sum     = 9'd0;
        reg_wr  = 1'b0;
        z_n     = z;
        c_n     = c;
        ie_n    = ie;
        svc_clr = 1'b0;
        port_wr = 1'b0;
        duty_wr = 1'b0;
        case (op)
            OP_LDI: begin res = imm; reg_wr = 1'b1; end
            OP_MOV: begin res = b;   reg_wr = 1'b1; end
            OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; res = sum[7:0]; c_n = sum[8]; reg_wr = 1'b1; end
            OP_SUB: begin sum = {1'b0, a} - {1'b0, b}; res = sum[7:0]; c_n = sum[8]; reg_wr = 1'b1; end
            OP_AND: begin res = a & b; c_n = 1'b0; reg_wr = 1'b1; end
            OP_OR:  begin res = a | b; c_n = 1'b0; reg_wr = 1'b1; end
            OP_XOR: begin res = a ^ b; c_n = 1'b0; reg_wr = 1'b1; end
            OP_SHL: begin res = {a[6:0], 1'b0}; c_n = a[7]; reg_wr = 1'b1; end
            OP_SHR: begin res = {1'b0, a[7:1]}; c_n = a[0]; reg_wr = 1'b1; end
            OP_IN:  begin res = in_val; reg_wr = 1'b1; end
            OP_OUT: begin
                duty_wr = imm[2];
                port_wr = ~imm[2] && (imm[1:0] != OUT_NONE);
            end
            OP_JMP: pc_n = imm;
            OP_JZ:  if (z)  pc_n = imm;
            OP_JNZ: if (!z) pc_n = imm;
            OP_SYS: begin
                case (imm[1:0])
                    SYS_HALT: pc_n = pc;
                    // Outside service RETI is a plain NOP
                    SYS_RETI: if (in_service) begin
                        pc_n    = epc;
                        z_n     = ez;
                        c_n     = ec;
                        svc_clr = 1'b1;
                    end
                    SYS_EI:   ie_n = 1'b1;
                    default:  ie_n = 1'b0;
                endcase
            end
            default: ;
        endcase
        if (alu_op) z_n = (res == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= 8'd0;
            epc        <= 8'd0;
            z          <= 1'b0;
            c          <= 1'b0;
            ez         <= 1'b0;
            ec         <= 1'b0;
            ie         <= 1'b1;
            in_service <= 1'b0;
            pending    <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_prev  <= 1'b0;
            out_port   <= 24'd0;
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else begin
            sync1     <= io.inputPort[5];
            sync2     <= sync1;
            sync_prev <= sync2;
            // A new edge in the take cycle survives so it is not lost
            pending   <= (pending & ~take) | fall;
            if (take) begin
                epc        <= pc;
                ez         <= z;
                ec         <= c;
                pc         <= ISR_VEC;
                in_service <= 1'b1;
            end else begin
                pc <= pc_n;
                z  <= z_n;
                c  <= c_n;
                ie <= ie_n;
                if (svc_clr) in_service <= 1'b0;
                if (reg_wr)  regs[rd] <= res;
                if (port_wr) out_port[{imm[1:0], 3'b000} +: 8] <= a;
            end
        end
    end

    assign io.outputPort = out_port;

    rk2040_pwm u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_wr  (duty_wr & ~take),
        .duty_sel (imm[1:0]),
        .duty_dat (a),
        .pwm      (io.outputPWM)
    );
endmodule

// File: tb/tb_rk2040.sv
// Lockstep bench: an instruction-level model of the core runs beside the DUT under random inputs.
`timescale 1ns/1ps
module tb_rk2040;
    import rk2040_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rk2040_if io();
    rk2040 #(.PROGRAM(1)) dut (.clk(clk), .rst(rst), .io(io));

    int errors = 0;
    int checks = 0;

    int          m_pc, m_epc, m_z, m_c, m_ez, m_ec, m_ie, m_ins, m_pend, m_cnt;
    int          m_r [8];
    int          m_duty [4];
    logic [23:0] m_out;
    logic [3:0]  m_pwm;
    bit          samples [$];

    bit b5;
    int hold, hi0, hi1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_epc = 0; m_z = 0; m_c = 0; m_ez = 0; m_ec = 0;
        m_ie = 1; m_ins = 0; m_pend = 0; m_cnt = 0;
        m_out = '0; m_pwm = '0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        for (int i = 0; i < 4; i++) m_duty[i] = 0;
        samples = {1'b0, 1'b0, 1'b0};
    endtask

    task automatic execute();
        logic [15:0] w;
        int op, rd, rs, imm, a, b, r, nxt, sel;
        w   = rom_word(1, m_pc[7:0]);
        op  = int'(w[15:12]);
        rd  = int'(w[11:9]);
        rs  = int'(w[8:6]);
        imm = int'(w[7:0]);
        a   = m_r[rd];
        b   = m_r[rs];
        r   = 0;
        nxt = (m_pc + 1) % 256;
        sel = imm % 8;
        case (op)
            1: m_r[rd] = imm;
            2: m_r[rd] = b;
            3: begin r = a + b; m_c = (r > 255) ? 1 : 0; r = r % 256; end
            4: begin m_c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
            5: begin r = a & b; m_c = 0; end
            6: begin r = a | b; m_c = 0; end
            7: begin r = a ^ b; m_c = 0; end
            8: begin m_c = a / 128; r = (a * 2) % 256; end
            9: begin m_c = a % 2; r = a / 2; end
            10: case (sel)
                    0: m_r[rd] = int'(io.inputPort[7:0]);
                    1: m_r[rd] = int'(io.inputPort[15:8]);
                    2: m_r[rd] = int'(io.inputPort[23:16]);
                    3: m_r[rd] = int'(io.ADC0);
                    4: m_r[rd] = int'(io.ADC1);
                    5: m_r[rd] = int'(io.ADC2);
                    default: m_r[rd] = 0;
                endcase
            11: if (sel < 3) m_out[sel*8 +: 8] = a[7:0];
                else if (sel >= 4) m_duty[sel-4] = a;
            12: nxt = imm;
            13: if (m_z == 1) nxt = imm;
            14: if (m_z == 0) nxt = imm;
            15: case (imm % 4)
                    0: nxt = m_pc;
                    1: if (m_ins == 1) begin nxt = m_epc; m_z = m_ez; m_c = m_ec; m_ins = 0; end
                    2: m_ie = 1;
                    default: m_ie = 0;
                endcase
            default: ;
        endcase
        if (op >= 3 && op <= 9) begin
            m_r[rd] = r;
            m_z = (r == 0) ? 1 : 0;
        end
        m_pc = nxt;
    endtask

    // Advance the model across the coming rising edge, then compare at the falling edge.
    task automatic tick();
        int  n;
        bit  fall_seen, take;
        n         = samples.size();
        fall_seen = (samples[n-2] == 1'b0) && (samples[n-3] == 1'b1);
        take      = (m_pend == 1) && (m_ie == 1) && (m_ins == 0);
        samples.push_back(io.inputPort[5]);
        if (samples.size() > 8) samples.delete(0);
        for (int i = 0; i < 4; i++) m_pwm[i] = (m_cnt < m_duty[i]);
        m_cnt = (m_cnt + 1) % 256;
        if (take) begin
            m_epc = m_pc; m_ez = m_z; m_ec = m_c;
            m_pc = 128; m_ins = 1;
            m_pend = fall_seen ? 1 : 0;
        end else begin
            if (fall_seen) m_pend = 1;
            execute();
        end
        @(negedge clk);
        chk("pc", {24'd0, dut.pc}, m_pc);
        chk("outputPort", {8'd0, io.outputPort}, {8'd0, m_out});
        chk("outputPWM", {28'd0, io.outputPWM}, {28'd0, m_pwm});
    endtask

    task automatic drive_rand(bit bit5, bit lo2);
        logic [23:0] v;
        v = 24'($urandom);
        v[5] = bit5;
        if (lo2) v[16] = 1'b1;
        else     v[17:16] = 2'b00;
        io.inputPort = v;
        io.ADC0 = 8'($urandom);
        io.ADC1 = 8'($urandom);
        io.ADC2 = 8'($urandom);
    endtask

    initial begin
        io.inputPort = '0;
        io.ADC0 = '0;
        io.ADC1 = '0;
        io.ADC2 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputPort", {8'd0, io.outputPort}, 32'd0);
        chk("reset_outputPWM", {28'd0, io.outputPWM}, 32'd0);
        chk("reset_pc", {24'd0, dut.pc}, 32'd0);

        // Directed start: arithmetic, JZ, duty 64, ADC echo
        io.ADC0 = 8'h12;
        io.ADC1 = 8'h34;
        io.ADC2 = 8'h56;
        rst = 1'b0;
        model_reset();
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 1) chk("pc_steps", {24'd0, dut.pc}, 32'd1);
            if (t == 4) begin
                chk("add_out_byte0", {8'd0, io.outputPort}, 32'h000008);
                chk("add_z", {31'd0, dut.z}, 32'd0);
                chk("add_c", {31'd0, dut.c}, 32'd0);
            end
            if (t == 7) begin
                chk("wrap_z", {31'd0, dut.z}, 32'd1);
                chk("wrap_c", {31'd0, dut.c}, 32'd1);
                chk("wrap_r1", {24'd0, dut.regs[1]}, 32'd0);
            end
            if (t == 8) chk("jz_taken", {24'd0, dut.pc}, 32'h09);
        end
        chk("adc_echo", {8'd0, io.outputPort}, 32'h563412);

        // PWM duty 64 on channel 0, duty 0 on channel 1 over one full counter period
        hi0 = 0;
        hi1 = 0;
        for (int t = 0; t < 280; t++) begin
            drive_rand(1'b0, 1'b1);
            tick();
            if (t >= 10 && t < 266) begin
                hi0 += int'(io.outputPWM[0]);
                hi1 += int'(io.outputPWM[1]);
            end
        end
        chk("pwm0_duty64", hi0, 32'd64);
        chk("pwm1_duty0", hi1, 32'd0);

        // Random interrupt edges against the running loop
        b5 = 1'b0;
        hold = 0;
        for (int t = 0; t < 3000; t++) begin
            if (hold == 0) begin
                b5 = ~b5;
                hold = $urandom_range(1, 30);
            end
            hold--;
            drive_rand(b5, 1'b1);
            tick();
        end

        // Mid-run reset with bit 5 high at release: aborts at once, no edge afterwards
        drive_rand(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_pc", {24'd0, dut.pc}, 32'd0);
        chk("midreset_outputPort", {8'd0, io.outputPort}, 32'd0);
        chk("midreset_outputPWM", {28'd0, io.outputPWM}, 32'd0);
        chk("midreset_pending", {31'd0, dut.pending}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 200; t++) begin
            drive_rand(1'b1, 1'b1);
            tick();
        end
        chk("no_edge_after_release", {31'd0, dut.in_service}, 32'd0);

        // HALT, interrupt out of HALT, back-to-back edge serviced after RETI
        for (int t = 0; t < 80; t++) begin
            drive_rand(1'b1, 1'b0);
            tick();
        end
        chk("halt_holds", {24'd0, dut.pc}, 32'h27);
        for (int t = 1; t <= 4; t++) begin
            drive_rand(1'b0, 1'b0);
            tick();
            if (t == 3) chk("pending_3rd_edge", {31'd0, dut.pending}, 32'd1);
        end
        chk("isr_entry", {24'd0, dut.pc}, 32'h80);
        drive_rand(1'b1, 1'b0);
        tick();
        chk("isr_first_instr", {24'd0, dut.pc}, 32'h81);
        for (int t = 0; t < 6; t++) begin
            drive_rand(1'b0, 1'b0);
            tick();
        end
        chk("reti_to_halt", {24'd0, dut.pc}, 32'h27);
        drive_rand(1'b0, 1'b0);
        tick();
        chk("second_edge_taken", {24'd0, dut.pc}, 32'h80);
        for (int t = 0; t < 7; t++) begin
            drive_rand(1'b0, 1'b0);
            tick();
        end
        chk("halt_after_second_isr", {24'd0, dut.pc}, 32'h27);
        chk("service_cleared", {31'd0, dut.in_service}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
